// File: rtl/dwt97_lift_step_if.sv
// Pair-stream bus used on both sides of the 9/7 lifting step: handshake, frame/line
// markers and a packed {odd,even} sample pair.
interface dwt97_lift_step_if #(
    parameter int DataWidth = 16
) ();
    logic                     ready;
    logic                     valid;
    logic                     sof;
    logic                     eol;
    logic [2*DataWidth-1:0]   data;

    modport master (output valid, output sof, output eol, output data, input ready);
    modport slave  (input valid, input sof, input eol, input data, output ready);
endinterface

// File: rtl/dwt97_lift_step.sv
// One 9/7 lifting step: odd'[n] = odd[n] + C*(even[n] + even[n+1]), even passes through.
// A hold register pairs each sample with its successor; a 2-stage pipe does multiply and round/saturate.
module dwt97_lift_step #(
    parameter int DataWidth = 16,
    parameter int CoefWidth = 18,
    parameter int FracBits  = 14,
    parameter int Coef      = -25987
) (
    input  logic              clk_i,
    input  logic              rst_i,
    dwt97_lift_step_if.slave  s,
    dwt97_lift_step_if.master m
);

    localparam int SW = DataWidth + 1;
    localparam int PW = DataWidth + CoefWidth + 1;
    localparam logic signed [CoefWidth-1:0] CoefS = CoefWidth'(Coef);
    localparam logic signed [PW:0]          Half  = {{PW{1'b0}}, 1'b1} << (FracBits - 1);

    // Round half up, then drop the fractional bits with an arithmetic shift.
    function automatic logic signed [PW:0] round_shift(input logic signed [PW-1:0] p);
        logic signed [PW:0] t;
        t = $signed({p[PW-1], p}) + Half;
        return t >>> FracBits;
    endfunction

    function automatic logic signed [DataWidth-1:0] sat(input logic signed [PW:0] v);
        if ((&v[PW:DataWidth-1]) || (~|v[PW:DataWidth-1])) begin
            return v[DataWidth-1:0];
        end else if (v[PW]) begin
            return {1'b1, {(DataWidth-1){1'b0}}};
        end else begin
            return {1'b0, {(DataWidth-1){1'b1}}};
        end
    endfunction

    logic                          h_vld_q, h_vld_d;
    logic                          h_sof_q, h_sof_d;
    logic signed [DataWidth-1:0]   h_even_q, h_even_d;
    logic signed [DataWidth-1:0]   h_odd_q, h_odd_d;

    logic                          vld_p1_q, vld_p1_d;
    logic                          sof_p1_q, sof_p1_d;
    logic                          eol_p1_q, eol_p1_d;
    logic signed [DataWidth-1:0]   even_p1_q, even_p1_d;
    logic signed [DataWidth-1:0]   odd_p1_q, odd_p1_d;
    logic signed [PW-1:0]          prod_p1_q, prod_p1_d;

    logic                          vld_p2_q, vld_p2_d;
    logic                          sof_p2_q, sof_p2_d;
    logic                          eol_p2_q, eol_p2_d;
    logic [2*DataWidth-1:0]        data_p2_q, data_p2_d;

    logic                          en, acc, issue;
    logic signed [DataWidth-1:0]   in_even, in_odd;
    logic signed [SW-1:0]          sum;
    logic signed [PW:0]            rnd, odd_ext;
    logic signed [DataWidth-1:0]   odd_new;

    assign en      = ~vld_p2_q | m.ready;
    assign s.ready = en;
    assign acc     = s.valid & en;
    assign issue   = acc & h_vld_q;

    assign in_even = s.data[DataWidth-1:0];
    assign in_odd  = s.data[2*DataWidth-1:DataWidth];
    assign sum     = $signed({in_even[DataWidth-1], in_even}) + $signed({h_even_q[DataWidth-1], h_even_q});

    assign rnd     = round_shift(prod_p1_q);
    assign odd_ext = $signed({{(PW+1-DataWidth){odd_p1_q[DataWidth-1]}}, odd_p1_q});
    assign odd_new = sat(odd_ext + rnd);

    assign m.valid = vld_p2_q;
    assign m.sof   = sof_p2_q;
    assign m.eol   = eol_p2_q;
    assign m.data  = data_p2_q;

    always_comb begin
        h_vld_d   = h_vld_q;
        h_sof_d   = h_sof_q;
        h_even_d  = h_even_q;
        h_odd_d   = h_odd_q;
        vld_p1_d  = vld_p1_q;
        sof_p1_d  = sof_p1_q;
        eol_p1_d  = eol_p1_q;
        even_p1_d = even_p1_q;
        odd_p1_d  = odd_p1_q;
        prod_p1_d = prod_p1_q;
        vld_p2_d  = vld_p2_q;
        sof_p2_d  = sof_p2_q;
        eol_p2_d  = eol_p2_q;
        data_p2_d = data_p2_q;
        if (en) begin
            // stage p1: pair H with the incoming even; a sof while H is full closes the old line
            vld_p1_d  = issue;
            sof_p1_d  = h_sof_q;
            eol_p1_d  = s.eol | s.sof;
            even_p1_d = h_even_q;
            odd_p1_d  = h_odd_q;
            prod_p1_d = $signed({{(PW-SW){sum[SW-1]}}, sum})
                      * $signed({{(PW-CoefWidth){CoefS[CoefWidth-1]}}, CoefS});
            // stage p2: round, add and saturate into the output register
            vld_p2_d  = vld_p1_q;
            sof_p2_d  = sof_p1_q;
            eol_p2_d  = eol_p1_q;
            data_p2_d = {odd_new, even_p1_q};
            if (acc) begin
                h_vld_d  = ~s.eol;
                h_sof_d  = s.sof;
                h_even_d = in_even;
                h_odd_d  = in_odd;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_vld_q   <= 1'b0;
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            sof_p2_q  <= 1'b0;
            eol_p2_q  <= 1'b0;
            data_p2_q <= '0;
        end else begin
            h_vld_q   <= h_vld_d;
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p2_d;
            sof_p2_q  <= sof_p2_d;
            eol_p2_q  <= eol_p2_d;
            data_p2_q <= data_p2_d;
        end
    end

    always_ff @(posedge clk_i) begin
        h_sof_q   <= h_sof_d;
        h_even_q  <= h_even_d;
        h_odd_q   <= h_odd_d;
        sof_p1_q  <= sof_p1_d;
        eol_p1_q  <= eol_p1_d;
        even_p1_q <= even_p1_d;
        odd_p1_q  <= odd_p1_d;
        prod_p1_q <= prod_p1_d;
    end

endmodule

// File: tb/tb_dwt97_lift_step.sv
// Bench for dwt97_lift_step: four instances with different coefficients share one input
// stream; every output beat is scored against a plain-arithmetic lifting model.
module tb_dwt97_lift_step;

    localparam int NI = 4;
    localparam int CF [NI] = '{-25987, -16384, 8192, 16384};

    typedef struct packed {
        logic                 sof;
        logic                 eol;
        logic [NI-1:0][31:0]  d;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid, s_sof, s_eol;
    logic [31:0] s_data;
    logic        m_ready;
    logic        s_rdy   [NI];
    logic        m_valid [NI];
    logic        m_sof   [NI];
    logic        m_eol   [NI];
    logic [31:0] m_data  [NI];

    int    n_cmp = 0;
    int    n_err = 0;
    int    rdy_mode = 0;
    int    exp_sof, exp_eol;
    int    le [64];
    int    lo [64];
    beat_t exp_q [$];
    beat_t hist  [$];
    beat_t held, cur;
    bit    hold_pend = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dwt97_lift_step_if #(.DataWidth(16)) s_if ();
        dwt97_lift_step_if #(.DataWidth(16)) m_if ();
        assign s_if.valid = s_valid;
        assign s_if.sof   = s_sof;
        assign s_if.eol   = s_eol;
        assign s_if.data  = s_data;
        assign s_rdy[g]   = s_if.ready;
        assign m_if.ready = m_ready;
        assign m_valid[g] = m_if.valid;
        assign m_sof[g]   = m_if.sof;
        assign m_eol[g]   = m_if.eol;
        assign m_data[g]  = m_if.data;
        dwt97_lift_step #(.DataWidth(16), .CoefWidth(18), .FracBits(14), .Coef(CF[g])) u_dut (
            .clk_i (clk),
            .rst_i (rst),
            .s     (s_if),
            .m     (m_if)
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // odd + round(C/2^14 * (e0+e1)) with ties going up, clamped to 16 bits
    function automatic logic [15:0] model_odd(input int c, input int e0, input int e1, input int o);
        real    y;
        longint v;
        y = $floor(real'(e0 + e1) * real'(c) / 16384.0 + 0.5);
        v = longint'(o) + longint'(y);
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        return v[15:0];
    endfunction

    function automatic int rnd16();
        logic [15:0] r;
        r = 16'($urandom);
        return int'($signed(r));
    endfunction

    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ($urandom_range(0, 3) != 0);
                default: m_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            cur.sof = m_sof[0];
            cur.eol = m_eol[0];
            for (int i = 0; i < NI; i++) cur.d[i] = m_data[i];
            if (hold_pend) begin
                chk("hold_valid", m_valid[0], 1);
                chk("hold_ctl", {cur.sof, cur.eol}, {held.sof, held.eol});
                for (int i = 0; i < NI; i++) chk($sformatf("hold_data%0d", i), cur.d[i], held.d[i]);
            end
            if (m_valid[0] && m_ready) begin
                hist.push_back(cur);
                chk("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("sb_ctl", {cur.sof, cur.eol}, {e.sof, e.eol});
                    for (int i = 0; i < NI; i++) chk($sformatf("sb_data%0d", i), cur.d[i], e.d[i]);
                end
            end
            hold_pend = m_valid[0] && !m_ready;
            held = cur;
        end
    end

    task automatic send_pair(input int e, input int o, input bit sof, input bit eol);
        int t;
        s_valid = 1'b1;
        s_data  = {o[15:0], e[15:0]};
        s_sof   = sof;
        s_eol   = eol;
        t = 0;
        forever begin
            @(negedge clk);
            if (s_rdy[0]) break;
            t++;
            if (t > 1000) begin
                chk("accept_timeout", t, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic send_line(input int len, input bit sof_first, input bit gaps,
                             input bit push_exp, input bit with_eol);
        if (push_exp) begin
            for (int k = 0; k < len - 1; k++) begin
                beat_t b;
                b.sof = sof_first && (k == 0);
                b.eol = (k == len - 2);
                for (int i = 0; i < NI; i++) b.d[i] = {model_odd(CF[i], le[k], le[k+1], lo[k]), le[k][15:0]};
                exp_q.push_back(b);
                exp_sof += int'(b.sof);
                exp_eol += int'(b.eol);
            end
        end
        for (int k = 0; k < len; k++) begin
            send_pair(le[k], lo[k], sof_first && (k == 0), with_eol && (k == len - 1));
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("drain", exp_q.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int n_sof, n_eol;
        rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0; s_data = '0;
        exp_sof = 0; exp_eol = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) chk("rst_valid", m_valid[i], 0);
        chk("rst_sof", m_sof[0], 0);
        chk("rst_eol", m_eol[0], 0);
        chk("rst_data", m_data[0], 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_mode = 0;
        @(posedge clk);
        #1;

        // unit negative coefficient: (10,3),(20,5),(30,7,eol)
        hist.delete();
        le[0] = 10; le[1] = 20; le[2] = 30; lo[0] = 3; lo[1] = 5; lo[2] = 7;
        send_line(3, 1, 0, 1, 1);
        drain();
        chk("neg1_count", hist.size(), 2);
        if (hist.size() >= 2) begin
            chk("neg1_b0", hist[0].d[1], 32'hFFE5_000A);
            chk("neg1_b1", hist[1].d[1], 32'hFFD3_0014);
            chk("neg1_f0", {hist[0].sof, hist[0].eol}, 2'b10);
            chk("neg1_f1", {hist[1].sof, hist[1].eol}, 2'b01);
        end

        // rounding ties with C = 0.5: evens (1,0) and (-1,0)
        hist.delete();
        le[0] = 1;  le[1] = 0; lo[0] = 0; lo[1] = 0;
        send_line(2, 1, 0, 1, 1);
        le[0] = -1; le[1] = 0;
        send_line(2, 0, 0, 1, 1);
        drain();
        chk("round_count", hist.size(), 2);
        if (hist.size() >= 2) begin
            chk("round_pos", hist[0].d[2], 32'h0001_0001);
            chk("round_neg", hist[1].d[2], 32'h0000_FFFF);
        end

        // saturation with C = 1.0 at both rails
        hist.delete();
        le[0] = 32767;  le[1] = 32767;  lo[0] = 32767;  lo[1] = 0;
        send_line(2, 0, 0, 1, 1);
        le[0] = -32768; le[1] = -32768; lo[0] = -32768; lo[1] = 0;
        send_line(2, 0, 0, 1, 1);
        drain();
        chk("sat_count", hist.size(), 2);
        if (hist.size() >= 2) begin
            chk("sat_hi", hist[0].d[3], 32'h7FFF_7FFF);
            chk("sat_lo", hist[1].d[3], 32'h8000_8000);
        end

        // a one-pair line produces nothing
        hist.delete();
        send_pair(5, 5, 1, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("single_none", hist.size(), 0);

        // 64-pair line at full rate with a 5-cycle downstream stall mid-line
        hist.delete();
        for (int k = 0; k < 64; k++) begin le[k] = rnd16(); lo[k] = rnd16(); end
        fork
            send_line(64, 1, 0, 1, 1);
            begin
                repeat (20) @(posedge clk);
                rdy_mode = 2;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_sready", s_rdy[0], 0);
                end
                rdy_mode = 0;
            end
        join
        drain();
        chk("line64_count", hist.size(), 63);

        // reset after three pairs of a line, then a clean line
        rdy_mode = 2;
        for (int k = 0; k < 3; k++) begin le[k] = rnd16(); lo[k] = rnd16(); end
        send_line(3, 1, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        hist.delete();
        rdy_mode = 0;
        repeat (5) begin
            @(negedge clk);
            chk("rst_idle", m_valid[0], 0);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 6; k++) begin le[k] = rnd16(); lo[k] = rnd16(); end
        send_line(6, 1, 0, 1, 1);
        drain();
        chk("post_rst_count", hist.size(), 5);

        // random lines, random gaps, random backpressure
        hist.delete();
        exp_sof = 0; exp_eol = 0;
        rdy_mode = 1;
        for (int ln = 0; ln < 100; ln++) begin
            int len;
            len = $urandom_range(1, 40);
            for (int k = 0; k < len; k++) begin le[k] = rnd16(); lo[k] = rnd16(); end
            send_line(len, (ln % 10) == 0, 1, 1, 1);
        end
        rdy_mode = 0;
        drain();
        n_sof = 0; n_eol = 0;
        foreach (hist[i]) begin
            n_sof += int'(hist[i].sof);
            n_eol += int'(hist[i].eol);
        end
        chk("rand_sof_count", n_sof, exp_sof);
        chk("rand_eol_count", n_eol, exp_eol);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
